// File: rtl/approx_mult_pkg.sv
// Shared definitions for the approximate multiplier front end.
//   state_t    : accumulator control states
//   col_mask   : column mask that clears the t low-order product columns
//   comp_const : half-truncated-LSB rounding compensation for a given t
package approx_mult_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Callers size-cast the 64-bit result down to their product width.
  function automatic logic [63:0] col_mask(input int unsigned t);
    if (t >= 64) return 64'd0;
    return 64'hFFFF_FFFF_FFFF_FFFF << t;
  endfunction

  function automatic logic [63:0] comp_const(input int unsigned t);
    if (t == 0) return 64'd0;
    return 64'd1 << (t - 1);
  endfunction

endpackage

// File: rtl/csa_3to2.sv
// Bitwise 3:2 carry-save compressor.
//   x, y, z : three W-bit addends
//   sum     : x ^ y ^ z
//   carry   : majority(x, y, z) shifted left one column, truncated to W bits
module csa_3to2 #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  logic [W-1:0] maj;

  assign sum   = x ^ y ^ z;
  assign maj   = (x & y) | (x & z) | (y & z);
  assign carry = maj << 1;

endmodule

// File: rtl/approx_pp_accumulator.sv
// Sequential partial-product accumulator feeding a three-operand adder.
// One partial-product row per cycle is carry-save accumulated; the low t
// columns of each row are masked off (t = min(in_trunc, WIDTH)).
//
// Optional feature macro: APPROX_COMP_EN
//   defined   -> out_c = 2^(t-1) for t >= 1, else 0
//   undefined -> out_c = 0, no compensation logic
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    operand handshake (in_a, in_b, in_trunc)
//   out_valid/out_ready  result handshake (out_a, out_b, out_c, out_cin)
//   busy                 high while accumulating or holding a result
module approx_pp_accumulator
  import approx_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned TW    = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [TW-1:0]        in_trunc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_a,
  output logic [2*WIDTH-1:0]   out_b,
  output logic [2*WIDTH-1:0]   out_c,
  output logic                 out_cin,
  output logic                 busy
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned KW = $clog2(WIDTH);

  state_t          state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [TW-1:0]    t_q;
  logic [KW-1:0]    k_q;
  logic [PW-1:0]    s_q, c_q;

  logic [TW-1:0]    t_clamp;
  logic [PW-1:0]    mask;
  logic [PW-1:0]    a_ext;
  logic [PW-1:0]    row;
  logic [PW-1:0]    s_next, c_next;

  assign t_clamp = (32'(in_trunc) > WIDTH) ? TW'(WIDTH) : in_trunc;

  assign mask  = PW'(col_mask(32'(t_q)));
  assign a_ext = PW'(a_q);
  assign row   = b_q[k_q] ? ((a_ext << k_q) & mask) : '0;

  csa_3to2 #(.W(PW)) u_csa (
    .x     (s_q),
    .y     (c_q),
    .z     (row),
    .sum   (s_next),
    .carry (c_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Handshake outputs depend on state_q only, never on in_valid/out_ready.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ACCUM;
      end
      ACCUM: begin
        busy = 1'b1;
        if (k_q == KW'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      t_q <= '0;
      k_q <= '0;
      s_q <= '0;
      c_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q <= in_a;
            b_q <= in_b;
            t_q <= t_clamp;
            k_q <= '0;
            s_q <= '0;
            c_q <= '0;
          end
        end
        ACCUM: begin
          s_q <= s_next;
          c_q <= c_next;
          k_q <= k_q + KW'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_a   = s_q;
  assign out_b   = c_q;
  assign out_cin = 1'b0;

`ifdef APPROX_COMP_EN
  assign out_c = PW'(comp_const(32'(t_q)));
`else
  assign out_c = '0;
`endif

endmodule

// File: doc/approx_pp_accumulator.md
# approx_pp_accumulator

Sequential partial-product front end of the approximate multiplier. It accepts two WIDTH-bit unsigned operands and an accuracy-control value, then generates and carry-save accumulates one partial-product row per cycle. The result is presented as three 2·WIDTH-bit operands plus a carry-in, which feed the downstream three-operand prefix adder directly. Accuracy is set by truncating the low-order columns and, optionally, adding a rounding compensation constant.

## Interface
- WIDTH, 16, multiplicand/multiplier width; output operands are 2·WIDTH bits
- TW, $clog2(WIDTH)+1, width of the truncation-control field
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand request
- in_ready  output  1  block idle and able to accept
- in_a  input  WIDTH  multiplicand
- in_b  input  WIDTH  multiplier
- in_trunc  input  TW  number of low product columns to truncate (0 = exact)
- out_valid  output  1  operands valid for the adder
- out_ready  input  1  adder consumes the operands
- out_a  output  2·WIDTH  carry-save sum vector
- out_b  output  2·WIDTH  carry-save carry vector, already aligned (shifted)
- out_c  output  2·WIDTH  truncation compensation constant
- out_cin  output  1  adder carry-in; tied 0 (reserved)
- busy  output  1  high in ACCUM or DONE

## Operation
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- States:
  - IDLE: in_ready=1. On in_valid: latch a, b, t = min(in_trunc, WIDTH); clear S, C and k; go to ACCUM.
  - ACCUM: per cycle, row = b[k] ? (a<<k) : 0, masked so that columns below t are zero. Update S' = S^C^row and C' = maj(S,C,row)<<1, truncated to 2·WIDTH bits. k increments each cycle. After k = WIDTH-1, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Output values:
  - out_a = S and out_b = C. Both are held stable throughout DONE.
  - out_a + out_b + out_c mod 2^(2·WIDTH) is the product. The consumer uses only the low 2·WIDTH bits of the adder sum. Bits above that are don't-care, because carry-out beyond 2·WIDTH is discarded during accumulation.
  - Approximate result = Σ masked rows + out_c.
- in_trunc values above WIDTH clamp to WIDTH. t=0 gives exact multiplication.
- Inputs are ignored outside IDLE, including in_valid asserted in DONE while out_ready is low.
- Reset values: state IDLE, in_ready=1, out_valid=0, busy=0, out_a=out_b=out_c=0, out_cin=0, k=0.
- Reset mid-operation aborts the product with no output. The first request after reset is fully correct.

## Timing
- The acceptance edge is E. ACCUM processes rows on edges E+1 … E+WIDTH.
- out_valid rises after edge E+WIDTH, which is WIDTH cycles after acceptance (16 at default).
- out_valid is held until out_ready. in_ready rises the cycle after the output handshake.
- Minimum period between acceptances is WIDTH+2 cycles.
- in_ready, out_valid and busy are decoded from registered state only, with no combinational path from in_valid or out_ready.
- The output handshake and a new in_valid in the same cycle do not overlap: the new request is taken in the following IDLE cycle.

## Configuration
- APPROX_COMP_EN:
  - Defined: out_c = 2^(t-1) for t≥1, and 0 for t=0 (half-truncated-LSB compensation).
  - Undefined: out_c is constant 0 and no compensation logic is built. Truncation masking is unaffected.

## Structure
- Package approx_mult_pkg holds:
  - the state enum (IDLE, ACCUM, DONE)
  - the default WIDTH
  - a function returning the column mask for a given t
  - a function returning the compensation constant
- One sub-module, csa_3to2: a parameterised bitwise 3:2 compressor producing sum and shifted carry vectors. It is instantiated once for the per-cycle update.

## Test plan
- a=16'hFFFF, b=16'hFFFF, t=0 → out_a+out_b+out_c mod 2^32 = 32'hFFFE0001, out_c=0, out_valid exactly 16 cycles after acceptance.
- a=3, b=5, t=0, out_ready tied 1 → sum = 15; in_ready returns one cycle after the handshake; a back-to-back request a=7, b=9 → sum 63.
- a=16'h000F, b=1, t=4 → row fully masked. Sum 8 with APPROX_COMP_EN defined, sum 0 without it.
- out_ready held 0 for 5 cycles in DONE, with in_valid pulsed → outputs stable, in_ready=0, request ignored; the release completes the handshake.
- rst_n asserted at ACCUM cycle 8 → out_valid=0, in_ready=1, busy=0 immediately; the next product a=100, b=200 gives 20000.
- in_trunc=31 (clamped to 16), a=b=16'hFFFF → sum = Σ (rows & 32'hFFFF0000) + 2^15 with the macro on.
